// File: rtl/param_bank_pkg.sv
// Shared definitions for the parameter bank controller: address map,
// constant indices, commit FSM states, control codes and ROI helper.
package param_bank_pkg;

    // Region bases. Matrix and constant regions are 0x80 aligned, so the
    // low seven address bits are the offset within the region.
    localparam logic [15:0] MATRIX_BASE  = 16'h0100;
    localparam logic [15:0] CONST_BASE   = 16'h0200;
    localparam logic [15:0] CONF_ADDR    = 16'h0050;
    localparam logic [15:0] ROI_BASE     = 16'h0080;
    localparam logic [15:0] CTRL_ADDR    = 16'h00F0;
    localparam logic [15:0] ERR_CLR_ADDR = 16'h00F1;

    // Cameras and scales are 0x10 apart inside their region.
    localparam int BANK_STRIDE_SHIFT = 4;
    localparam int NUM_CONSTS        = 5;
    localparam int NUM_MATRIX_ELEMS  = 9;

    // Data codes written to CTRL_ADDR.
    localparam logic [31:0] CTRL_ARM = 32'd1;
    localparam logic [31:0] CTRL_NOW = 32'd2;

    typedef enum logic [2:0] {
        K_A  = 3'd0,
        K_B  = 3'd1,
        K_W0 = 3'd2,
        K_W1 = 3'd3,
        K_W2 = 3'd4
    } const_idx_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } commit_state_e;

    typedef enum logic [2:0] {
        KIND_NONE    = 3'd0,
        KIND_MATRIX  = 3'd1,
        KIND_CONST   = 3'd2,
        KIND_CONF    = 3'd3,
        KIND_ROI     = 3'd4,
        KIND_CTRL    = 3'd5,
        KIND_ERR_CLR = 3'd6
    } addr_kind_e;

    typedef struct packed {
        logic [15:0] top;
        logic [15:0] bottom;
        logic [15:0] left;
        logic [15:0] right;
    } roi_bounds_t;

    // Corner plus fixed dimensions; 16-bit wrap is intentional and silent.
    function automatic roi_bounds_t calc_roi_bounds(input logic [15:0] y,
                                                    input logic [15:0] x,
                                                    input logic [15:0] h,
                                                    input logic [15:0] w);
        roi_bounds_t r;
        r.top    = y;
        r.bottom = y + h;
        r.left   = x;
        r.right  = x + w;
        return r;
    endfunction

endpackage

// File: rtl/param_addr_decode.sv
// Combinational address decoder shared by the write and read paths.
// Splits a 16-bit address into region kind, camera/scale index, element
// and a valid flag that covers out-of-range cameras, scales and elements.
module param_addr_decode
    import param_bank_pkg::*;
#(
    parameter int NUM_CAMERAS = 2,
    parameter int NUM_SCALES  = 3
) (
    input  logic [15:0] addr_i,
    output addr_kind_e  kind_o,
    output logic [2:0]  index_o,
    output logic [2:0]  elem_o,
    output logic [1:0]  row_o,
    output logic [1:0]  col_o,
    output logic        valid_o
);

    logic [3:0] low_nibble;

    assign low_nibble = addr_i[3:0];

    // Region match and bounds checks for the incoming address.
    always_comb begin
        kind_o  = KIND_NONE;
        index_o = 3'(addr_i[6:0] >> BANK_STRIDE_SHIFT);
        elem_o  = addr_i[2:0];
        row_o   = 2'(low_nibble / 4'd3);
        col_o   = 2'(low_nibble % 4'd3);
        valid_o = 1'b0;

        if (addr_i[15:7] == MATRIX_BASE[15:7]) begin
            kind_o  = KIND_MATRIX;
            valid_o = (32'(index_o) < NUM_CAMERAS) &&
                      (32'(low_nibble) < NUM_MATRIX_ELEMS);
        end else if (addr_i[15:7] == CONST_BASE[15:7]) begin
            kind_o  = KIND_CONST;
            valid_o = (32'(index_o) < NUM_SCALES) &&
                      (32'(low_nibble) < NUM_CONSTS);
        end else if (addr_i[15:2] == ROI_BASE[15:2]) begin
            kind_o  = KIND_ROI;
            valid_o = 1'b1;
        end else if (addr_i == CONF_ADDR) begin
            kind_o  = KIND_CONF;
            valid_o = 1'b1;
        end else if (addr_i == CTRL_ADDR) begin
            kind_o  = KIND_CTRL;
            valid_o = 1'b1;
        end else if (addr_i == ERR_CLR_ADDR) begin
            kind_o  = KIND_ERR_CLR;
            valid_o = 1'b1;
        end
    end

endmodule

// File: rtl/param_bank_controller.sv
// Shadow/active parameter bank for the DfDD and xform pipelines. Commands
// write the shadow bank; a commit copies it to the active bank either
// immediately or at the next frame start, so consumers never observe a
// partially updated set mid-frame.
module param_bank_controller
    import param_bank_pkg::*;
#(
    parameter int          NUM_CAMERAS = 2,
    parameter int          NUM_SCALES  = 3,
    parameter int          PRECISION   = 0,
    parameter logic [15:0] A  [NUM_SCALES] = '{default: 16'h3c00},
    parameter logic [15:0] B  [NUM_SCALES] = '{default: 16'h3c00},
    parameter logic [15:0] W0 [NUM_SCALES] = '{default: 16'h3c00},
    parameter logic [15:0] W1 [NUM_SCALES] = '{default: 16'h3c00},
    parameter logic [15:0] W2 [NUM_SCALES] = '{default: 16'h3c00},
    parameter logic [15:0] DEFAULT_CONFIDENCE_MINIMUM = 16'h0000,
    parameter logic [15:0] DEFAULT_PRE_XFORM_ROI_CORNER  [2] = '{16'd0, 16'd0},
    parameter logic [15:0] DEFAULT_POST_XFORM_ROI_CORNER [2] = '{16'd0, 16'd0},
    parameter logic [15:0] PRE_XFORM_ROI_DIMS  [2] = '{16'd480, 16'd512},
    parameter logic [15:0] POST_XFORM_ROI_DIMS [2] = '{16'd480, 16'd512},
    parameter logic [31:0] DEFAULT_BILINEAR_MATRIX [3][3] = '{
        '{32'h100, 32'h000, 32'h000},
        '{32'h000, 32'h100, 32'h000},
        '{32'h000, 32'h000, 32'h100}
    }
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    input  logic [15:0]          cmd_addr_i,
    input  logic [31:0]          cmd_data_i,
    input  logic                 frame_start_i,
    input  logic                 rd_en_i,
    input  logic [15:0]          rd_addr_i,
    output logic                 rd_valid_o,
    output logic [31:0]          rd_data_o,
    output logic [15:0]          a_o  [NUM_SCALES],
    output logic [15:0]          b_o  [NUM_SCALES],
    output logic [15:0]          w0_o [NUM_SCALES],
    output logic [15:0]          w1_o [NUM_SCALES],
    output logic [15:0]          w2_o [NUM_SCALES],
    output logic [10+PRECISION:0] bilinear_matrices_o [NUM_CAMERAS][3][3],
    output logic [15:0]          confidence_o,
    output logic [15:0]          pre_bilinear_roi_boundaries_o  [4],
    output logic [15:0]          post_bilinear_roi_boundaries_o [4],
    output logic                 commit_pending_o,
    output logic                 commit_done_o,
    output logic                 addr_err_o
);

    localparam int MATRIX_WIDTH = 11 + PRECISION;

    // One complete parameter set; roi holds pre y, pre x, post y, post x.
    typedef struct packed {
        logic [NUM_CAMERAS-1:0][2:0][2:0][MATRIX_WIDTH-1:0] mat;
        logic [NUM_SCALES-1:0][NUM_CONSTS-1:0][15:0]        cst;
        logic [15:0]                                         conf;
        logic [3:0][15:0]                                    roi;
    } bank_t;

    function automatic bank_t default_bank();
        bank_t b;
        b = '0;
        for (int c = 0; c < NUM_CAMERAS; c++) begin
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 3; k++) begin
                    b.mat[c][r][k] = MATRIX_WIDTH'(DEFAULT_BILINEAR_MATRIX[r][k]);
                end
            end
        end
        for (int s = 0; s < NUM_SCALES; s++) begin
            b.cst[s][K_A]  = A[s];
            b.cst[s][K_B]  = B[s];
            b.cst[s][K_W0] = W0[s];
            b.cst[s][K_W1] = W1[s];
            b.cst[s][K_W2] = W2[s];
        end
        b.conf   = DEFAULT_CONFIDENCE_MINIMUM;
        b.roi[0] = DEFAULT_PRE_XFORM_ROI_CORNER[0];
        b.roi[1] = DEFAULT_PRE_XFORM_ROI_CORNER[1];
        b.roi[2] = DEFAULT_POST_XFORM_ROI_CORNER[0];
        b.roi[3] = DEFAULT_POST_XFORM_ROI_CORNER[1];
        return b;
    endfunction

    localparam bank_t DEFAULT_BANK = default_bank();

    // Registered command (edge E0), decoded one edge later (E1).
    logic          cmd_valid_q, cmd_valid_d;
    logic [15:0]   cmd_addr_q,  cmd_addr_d;
    logic [31:0]   cmd_data_q,  cmd_data_d;

    bank_t         shadow_q, shadow_d;
    bank_t         active_q, active_d;
    commit_state_e state_q,  state_d;
    logic          commit_done_q, commit_done_d;
    logic          addr_err_q,    addr_err_d;
    logic          rd_valid_q,    rd_valid_d;
    logic [31:0]   rd_data_q,     rd_data_d;
    roi_bounds_t   pre_roi_q,  pre_roi_d;
    roi_bounds_t   post_roi_q, post_roi_d;

    addr_kind_e    wr_kind, rd_kind;
    logic [2:0]    wr_index, rd_index;
    logic [2:0]    wr_elem,  rd_elem;
    logic [1:0]    wr_row,   rd_row;
    logic [1:0]    wr_col,   rd_col;
    logic          wr_valid, rd_valid;

    logic          wr_en;
    logic          ctrl_arm;
    logic          ctrl_now;
    logic          err_clr;
    logic          commit_load;

    param_addr_decode #(
        .NUM_CAMERAS (NUM_CAMERAS),
        .NUM_SCALES  (NUM_SCALES)
    ) u_wr_decode (
        .addr_i  (cmd_addr_q),
        .kind_o  (wr_kind),
        .index_o (wr_index),
        .elem_o  (wr_elem),
        .row_o   (wr_row),
        .col_o   (wr_col),
        .valid_o (wr_valid)
    );

    param_addr_decode #(
        .NUM_CAMERAS (NUM_CAMERAS),
        .NUM_SCALES  (NUM_SCALES)
    ) u_rd_decode (
        .addr_i  (rd_addr_i),
        .kind_o  (rd_kind),
        .index_o (rd_index),
        .elem_o  (rd_elem),
        .row_o   (rd_row),
        .col_o   (rd_col),
        .valid_o (rd_valid)
    );

    assign wr_en    = cmd_valid_q && wr_valid;
    assign ctrl_arm = wr_en && (wr_kind == KIND_CTRL) && (cmd_data_q == CTRL_ARM);
    assign ctrl_now = wr_en && (wr_kind == KIND_CTRL) && (cmd_data_q == CTRL_NOW);
    assign err_clr  = wr_en && (wr_kind == KIND_ERR_CLR);

    // Commit FSM state register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only; the
        // always_comb blocks use blocking ones.
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Commit FSM next state; an immediate commit overrides a pending arm.
    always_comb begin
        // NOTE: every combinational output gets a default first so no
        // latch is inferred on paths that do not assign it.
        state_d     = state_q;
        commit_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_now) begin
                    commit_load = 1'b1;
                end else if (ctrl_arm) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (ctrl_now || frame_start_i) begin
                    commit_load = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command capture, shadow writes and the shadow-to-active copy.
    always_comb begin
        cmd_valid_d   = cmd_valid_i;
        cmd_addr_d    = cmd_addr_i;
        cmd_data_d    = cmd_data_i;
        shadow_d      = shadow_q;
        active_d      = active_q;
        commit_done_d = commit_load;

        if (wr_en) begin
            case (wr_kind)
                KIND_MATRIX: begin
                    for (int c = 0; c < NUM_CAMERAS; c++) begin
                        if (wr_index == 3'(c)) begin
                            shadow_d.mat[c][wr_row][wr_col] = cmd_data_q[MATRIX_WIDTH-1:0];
                        end
                    end
                end
                KIND_CONST: begin
                    for (int s = 0; s < NUM_SCALES; s++) begin
                        if (wr_index == 3'(s)) begin
                            shadow_d.cst[s][wr_elem] = cmd_data_q[15:0];
                        end
                    end
                end
                KIND_CONF: shadow_d.conf = cmd_data_q[15:0];
                KIND_ROI:  shadow_d.roi[wr_elem[1:0]] = cmd_data_q[15:0];
                default: ;
            endcase
        end

        // Active takes the pre-write shadow, so a write on the commit edge
        // waits in shadow for the next commit.
        if (commit_load) begin
            active_d = shadow_q;
        end
    end

    // Readback of the shadow bank and the sticky address-error flag.
    always_comb begin
        rd_valid_d = rd_en_i;
        rd_data_d  = '0;
        addr_err_d = addr_err_q;

        if (rd_en_i && rd_valid) begin
            case (rd_kind)
                KIND_MATRIX: begin
                    for (int c = 0; c < NUM_CAMERAS; c++) begin
                        if (rd_index == 3'(c)) begin
                            rd_data_d = 32'(shadow_q.mat[c][rd_row][rd_col]);
                        end
                    end
                end
                KIND_CONST: begin
                    for (int s = 0; s < NUM_SCALES; s++) begin
                        if (rd_index == 3'(s)) begin
                            rd_data_d = 32'(shadow_q.cst[s][rd_elem]);
                        end
                    end
                end
                KIND_CONF: rd_data_d = 32'(shadow_q.conf);
                KIND_ROI:  rd_data_d = 32'(shadow_q.roi[rd_elem[1:0]]);
                KIND_CTRL: rd_data_d = {30'b0, addr_err_q, state_q == ST_ARMED};
                default:   rd_data_d = '0;
            endcase
        end

        if (err_clr) begin
            addr_err_d = 1'b0;
        end
        if ((cmd_valid_q && !wr_valid) || (rd_en_i && !rd_valid)) begin
            addr_err_d = 1'b1;
        end
    end

    // ROI boundaries follow the active corners one cycle later.
    always_comb begin
        pre_roi_d  = calc_roi_bounds(active_q.roi[0], active_q.roi[1],
                                     PRE_XFORM_ROI_DIMS[0], PRE_XFORM_ROI_DIMS[1]);
        post_roi_d = calc_roi_bounds(active_q.roi[2], active_q.roi[3],
                                     POST_XFORM_ROI_DIMS[0], POST_XFORM_ROI_DIMS[1]);
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_valid_q   <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_data_q    <= '0;
            // NOTE: both banks are small flop arrays rather than RAM, so
            // they load their defaults under reset like any other register.
            shadow_q      <= DEFAULT_BANK;
            active_q      <= DEFAULT_BANK;
            commit_done_q <= 1'b0;
            addr_err_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            pre_roi_q     <= calc_roi_bounds(DEFAULT_BANK.roi[0], DEFAULT_BANK.roi[1],
                                             PRE_XFORM_ROI_DIMS[0], PRE_XFORM_ROI_DIMS[1]);
            post_roi_q    <= calc_roi_bounds(DEFAULT_BANK.roi[2], DEFAULT_BANK.roi[3],
                                             POST_XFORM_ROI_DIMS[0], POST_XFORM_ROI_DIMS[1]);
        end else begin
            cmd_valid_q   <= cmd_valid_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_data_q    <= cmd_data_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            commit_done_q <= commit_done_d;
            addr_err_q    <= addr_err_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            pre_roi_q     <= pre_roi_d;
            post_roi_q    <= post_roi_d;
        end
    end

    // Fan the active bank out to the per-scale and per-camera ports.
    always_comb begin
        for (int s = 0; s < NUM_SCALES; s++) begin
            a_o[s]  = active_q.cst[s][K_A];
            b_o[s]  = active_q.cst[s][K_B];
            w0_o[s] = active_q.cst[s][K_W0];
            w1_o[s] = active_q.cst[s][K_W1];
            w2_o[s] = active_q.cst[s][K_W2];
        end
        for (int c = 0; c < NUM_CAMERAS; c++) begin
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 3; k++) begin
                    bilinear_matrices_o[c][r][k] = active_q.mat[c][r][k];
                end
            end
        end
        pre_bilinear_roi_boundaries_o[0]  = pre_roi_q.top;
        pre_bilinear_roi_boundaries_o[1]  = pre_roi_q.bottom;
        pre_bilinear_roi_boundaries_o[2]  = pre_roi_q.left;
        pre_bilinear_roi_boundaries_o[3]  = pre_roi_q.right;
        post_bilinear_roi_boundaries_o[0] = post_roi_q.top;
        post_bilinear_roi_boundaries_o[1] = post_roi_q.bottom;
        post_bilinear_roi_boundaries_o[2] = post_roi_q.left;
        post_bilinear_roi_boundaries_o[3] = post_roi_q.right;
    end

    assign confidence_o     = active_q.conf;
    assign commit_pending_o = (state_q == ST_ARMED);
    assign commit_done_o    = commit_done_q;
    assign addr_err_o       = addr_err_q;
    assign rd_valid_o       = rd_valid_q;
    assign rd_data_o        = rd_data_q;

endmodule

// File: tb/tb_param_bank_controller.sv
// Directed bench for param_bank_controller: reset state, shadow isolation,
// framed and immediate commits, ROI wrap, write/commit collision, and
// address errors with reset while armed.
module tb_param_bank_controller;

    localparam int NC = 2;
    localparam int NS = 3;
    localparam int PREC = 8;
    localparam int MW = 11 + PREC;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cmd_valid_i;
    logic [15:0]   cmd_addr_i;
    logic [31:0]   cmd_data_i;
    logic          frame_start_i;
    logic          rd_en_i;
    logic [15:0]   rd_addr_i;
    logic          rd_valid_o;
    logic [31:0]   rd_data_o;
    logic [15:0]   a_o  [NS];
    logic [15:0]   b_o  [NS];
    logic [15:0]   w0_o [NS];
    logic [15:0]   w1_o [NS];
    logic [15:0]   w2_o [NS];
    logic [MW-1:0] bilinear_matrices_o [NC][3][3];
    logic [15:0]   confidence_o;
    logic [15:0]   pre_bilinear_roi_boundaries_o  [4];
    logic [15:0]   post_bilinear_roi_boundaries_o [4];
    logic          commit_pending_o;
    logic          commit_done_o;
    logic          addr_err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    param_bank_controller #(
        .NUM_CAMERAS (NC),
        .NUM_SCALES  (NS),
        .PRECISION   (PREC)
    ) dut (
        .clk_i                          (clk_i),
        .rst_i                          (rst_i),
        .cmd_valid_i                    (cmd_valid_i),
        .cmd_addr_i                     (cmd_addr_i),
        .cmd_data_i                     (cmd_data_i),
        .frame_start_i                  (frame_start_i),
        .rd_en_i                        (rd_en_i),
        .rd_addr_i                      (rd_addr_i),
        .rd_valid_o                     (rd_valid_o),
        .rd_data_o                      (rd_data_o),
        .a_o                            (a_o),
        .b_o                            (b_o),
        .w0_o                           (w0_o),
        .w1_o                           (w1_o),
        .w2_o                           (w2_o),
        .bilinear_matrices_o            (bilinear_matrices_o),
        .confidence_o                   (confidence_o),
        .pre_bilinear_roi_boundaries_o  (pre_bilinear_roi_boundaries_o),
        .post_bilinear_roi_boundaries_o (post_bilinear_roi_boundaries_o),
        .commit_pending_o               (commit_pending_o),
        .commit_done_o                  (commit_done_o),
        .addr_err_o                     (addr_err_o)
    );

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_cmd(input logic [15:0] addr, input logic [31:0] data);
        cmd_valid_i = 1'b1;
        cmd_addr_i  = addr;
        cmd_data_i  = data;
        tick();
        cmd_valid_i = 1'b0;
        cmd_addr_i  = '0;
        cmd_data_i  = '0;
    endtask

    task automatic read_req(input logic [15:0] addr);
        rd_en_i   = 1'b1;
        rd_addr_i = addr;
        tick();
        rd_en_i   = 1'b0;
        rd_addr_i = '0;
    endtask

    task automatic test_reset();
        logic [15:0] exp_roi [4];
        exp_roi = '{16'd0, 16'd480, 16'd0, 16'd512};
        rst_i         = 1'b1;
        cmd_valid_i   = 1'b0;
        cmd_addr_i    = '0;
        cmd_data_i    = '0;
        frame_start_i = 1'b0;
        rd_en_i       = 1'b0;
        rd_addr_i     = '0;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        for (int s = 0; s < NS; s++) begin
            total++;
            if (a_o[s] !== 16'h3c00) begin
                bad++; $display("FAIL reset_a[%0d]: got %h expected 3c00", s, a_o[s]);
            end
            total++;
            if (b_o[s] !== 16'h3c00) begin
                bad++; $display("FAIL reset_b[%0d]: got %h expected 3c00", s, b_o[s]);
            end
            total++;
            if (w2_o[s] !== 16'h3c00) begin
                bad++; $display("FAIL reset_w2[%0d]: got %h expected 3c00", s, w2_o[s]);
            end
        end
        for (int c = 0; c < NC; c++) begin
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 3; k++) begin
                    logic [MW-1:0] exp_m;
                    exp_m = (r == k) ? MW'(32'h100) : '0;
                    total++;
                    if (bilinear_matrices_o[c][r][k] !== exp_m) begin
                        bad++;
                        $display("FAIL reset_matrix[%0d][%0d][%0d]: got %h expected %h",
                                 c, r, k, bilinear_matrices_o[c][r][k], exp_m);
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (pre_bilinear_roi_boundaries_o[i] !== exp_roi[i]) begin
                bad++; $display("FAIL reset_pre_roi[%0d]: got %h expected %h",
                                i, pre_bilinear_roi_boundaries_o[i], exp_roi[i]);
            end
            total++;
            if (post_bilinear_roi_boundaries_o[i] !== exp_roi[i]) begin
                bad++; $display("FAIL reset_post_roi[%0d]: got %h expected %h",
                                i, post_bilinear_roi_boundaries_o[i], exp_roi[i]);
            end
        end
        total++;
        if ({commit_pending_o, commit_done_o, addr_err_o, rd_valid_o} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b expected 0000",
                            {commit_pending_o, commit_done_o, addr_err_o, rd_valid_o});
        end
        total++;
        if (rd_data_o !== 32'h0) begin
            bad++; $display("FAIL reset_rd_data: got %h expected 0", rd_data_o);
        end
        total++;
        if (confidence_o !== 16'h0) begin
            bad++; $display("FAIL reset_conf: got %h expected 0", confidence_o);
        end
    endtask

    task automatic test_shadow_isolation();
        write_cmd(16'h0201, 32'h0000_4000);
        tick();
        total++;
        if (b_o[0] !== 16'h3c00) begin
            bad++; $display("FAIL shadow_b0_active: got %h expected 3c00", b_o[0]);
        end
        total++;
        if (rd_valid_o !== 1'b0) begin
            bad++; $display("FAIL rd_valid_idle: got %b expected 0", rd_valid_o);
        end
        read_req(16'h0201);
        total++;
        if (rd_valid_o !== 1'b1) begin
            bad++; $display("FAIL rd_valid_resp: got %b expected 1", rd_valid_o);
        end
        total++;
        if (rd_data_o !== 32'h0000_4000) begin
            bad++; $display("FAIL rd_data_b0: got %h expected 00004000", rd_data_o);
        end
        tick();
        total++;
        if (rd_valid_o !== 1'b0) begin
            bad++; $display("FAIL rd_valid_drop: got %b expected 0", rd_valid_o);
        end
    endtask

    task automatic test_framed_commit();
        write_cmd(16'h0111, 32'h0000_0200);
        write_cmd(16'h00F0, 32'd1);
        tick();
        total++;
        if (commit_pending_o !== 1'b1) begin
            bad++; $display("FAIL armed_pending: got %b expected 1", commit_pending_o);
        end
        write_cmd(16'h00F0, 32'd1);
        tick();
        total++;
        if (commit_pending_o !== 1'b1) begin
            bad++; $display("FAIL rearm_pending: got %b expected 1", commit_pending_o);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (bilinear_matrices_o[1][0][1] !== MW'(32'h0)) begin
                bad++; $display("FAIL armed_matrix_hold: got %h expected 0",
                                bilinear_matrices_o[1][0][1]);
            end
            total++;
            if (commit_done_o !== 1'b0) begin
                bad++; $display("FAIL armed_done_quiet: got %b expected 0", commit_done_o);
            end
        end
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        total++;
        if (bilinear_matrices_o[1][0][1] !== MW'(32'h200)) begin
            bad++; $display("FAIL frame_matrix: got %h expected 00200",
                            bilinear_matrices_o[1][0][1]);
        end
        total++;
        if (commit_done_o !== 1'b1 || commit_pending_o !== 1'b0) begin
            bad++; $display("FAIL frame_done_pending: got %b%b expected 10",
                            commit_done_o, commit_pending_o);
        end
        total++;
        if (b_o[0] !== 16'h4000) begin
            bad++; $display("FAIL frame_b0: got %h expected 4000", b_o[0]);
        end
        tick();
        total++;
        if (commit_done_o !== 1'b0) begin
            bad++; $display("FAIL frame_done_single: got %b expected 0", commit_done_o);
        end
    endtask

    task automatic test_immediate_roi_wrap();
        logic [15:0] exp_roi [4];
        exp_roi = '{16'hFF00, 16'h00E0, 16'h0000, 16'h0200};
        write_cmd(16'h0080, 32'h0000_FF00);
        write_cmd(16'h00F0, 32'd2);
        tick();
        total++;
        if (commit_done_o !== 1'b1) begin
            bad++; $display("FAIL now_done: got %b expected 1", commit_done_o);
        end
        total++;
        if (pre_bilinear_roi_boundaries_o[0] !== 16'h0000) begin
            bad++; $display("FAIL roi_lag: got %h expected 0000",
                            pre_bilinear_roi_boundaries_o[0]);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (pre_bilinear_roi_boundaries_o[i] !== exp_roi[i]) begin
                bad++; $display("FAIL wrap_pre_roi[%0d]: got %h expected %h",
                                i, pre_bilinear_roi_boundaries_o[i], exp_roi[i]);
            end
        end
        total++;
        if (post_bilinear_roi_boundaries_o[1] !== 16'd480) begin
            bad++; $display("FAIL wrap_post_bottom: got %h expected 01e0",
                            post_bilinear_roi_boundaries_o[1]);
        end
    endtask

    task automatic test_back_to_back();
        write_cmd(16'h00F0, 32'd1);
        tick();
        write_cmd(16'h0050, 32'h0000_0010);
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        total++;
        if (commit_done_o !== 1'b1 || commit_pending_o !== 1'b0) begin
            bad++; $display("FAIL collide_done_pending: got %b%b expected 10",
                            commit_done_o, commit_pending_o);
        end
        total++;
        if (confidence_o !== 16'h0000) begin
            bad++; $display("FAIL collide_conf_old: got %h expected 0000", confidence_o);
        end
        read_req(16'h0050);
        total++;
        if (rd_data_o !== 32'h0000_0010) begin
            bad++; $display("FAIL collide_shadow: got %h expected 00000010", rd_data_o);
        end
        write_cmd(16'h00F0, 32'd2);
        tick();
        total++;
        if (confidence_o !== 16'h0010) begin
            bad++; $display("FAIL second_commit_conf: got %h expected 0010", confidence_o);
        end
    endtask

    task automatic test_addr_errors_reset();
        logic [15:0] exp_roi [4];
        exp_roi = '{16'd0, 16'd480, 16'd0, 16'd512};
        write_cmd(16'h00F0, 32'd3);
        tick();
        total++;
        if (addr_err_o !== 1'b0 || commit_pending_o !== 1'b0) begin
            bad++; $display("FAIL ctrl_ignored: got %b%b expected 00", addr_err_o, commit_pending_o);
        end
        write_cmd(16'h0230, 32'h0000_1234);
        tick();
        total++;
        if (addr_err_o !== 1'b1) begin
            bad++; $display("FAIL bad_scale_err: got %b expected 1", addr_err_o);
        end
        read_req(16'h00F0);
        total++;
        if (rd_data_o !== 32'h2) begin
            bad++; $display("FAIL status_err: got %h expected 00000002", rd_data_o);
        end
        write_cmd(16'h00F1, 32'h0);
        tick();
        total++;
        if (addr_err_o !== 1'b0) begin
            bad++; $display("FAIL err_clear: got %b expected 0", addr_err_o);
        end
        write_cmd(16'h0120, 32'h0000_0055);
        tick();
        total++;
        if (addr_err_o !== 1'b1) begin
            bad++; $display("FAIL bad_camera_err: got %b expected 1", addr_err_o);
        end
        write_cmd(16'h00F1, 32'h0);
        tick();
        read_req(16'h0300);
        total++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== 32'h0 || addr_err_o !== 1'b1) begin
            bad++; $display("FAIL unmapped_read: got v=%b d=%h e=%b expected v=1 d=0 e=1",
                            rd_valid_o, rd_data_o, addr_err_o);
        end
        write_cmd(16'h00F0, 32'd1);
        tick();
        read_req(16'h00F0);
        total++;
        if (rd_data_o !== 32'h3) begin
            bad++; $display("FAIL status_armed: got %h expected 00000003", rd_data_o);
        end
        rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        tick();
        total++;
        if ({commit_pending_o, commit_done_o, addr_err_o} !== 3'b000) begin
            bad++; $display("FAIL rst_flags: got %b expected 000",
                            {commit_pending_o, commit_done_o, addr_err_o});
        end
        total++;
        if (b_o[0] !== 16'h3c00 || confidence_o !== 16'h0) begin
            bad++; $display("FAIL rst_bank: got b0=%h conf=%h expected 3c00 0000",
                            b_o[0], confidence_o);
        end
        total++;
        if (bilinear_matrices_o[1][0][1] !== MW'(32'h0)) begin
            bad++; $display("FAIL rst_matrix: got %h expected 0", bilinear_matrices_o[1][0][1]);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (pre_bilinear_roi_boundaries_o[i] !== exp_roi[i]) begin
                bad++; $display("FAIL rst_pre_roi[%0d]: got %h expected %h",
                                i, pre_bilinear_roi_boundaries_o[i], exp_roi[i]);
            end
        end
        read_req(16'h0201);
        total++;
        if (rd_data_o !== 32'h0000_3c00) begin
            bad++; $display("FAIL rst_shadow_b0: got %h expected 00003c00", rd_data_o);
        end
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        total++;
        if (commit_done_o !== 1'b0) begin
            bad++; $display("FAIL rst_cancel_commit: got %b expected 0", commit_done_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_shadow_isolation();
        test_framed_commit();
        test_immediate_roi_wrap();
        test_back_to_back();
        test_addr_errors_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
